// File: rtl/scan_config_loader.sv
// ============================================================================
// Module   : scan_config_loader
// Purpose  : Loads one tile's configuration bitstream into its two scan chains
//            (the CLB chain first, then the connection chain SB->CB_top->
//            CB_right). Words arrive on a valid/ready stream, are serialised
//            MSB-first, and are shifted with a divided scan clock (clk/2).
// Ports    : clk, rst_n          - system clock, async active-low reset
//            start               - begin a load (honoured only while idle)
//            in_data/in_valid/in_ready - bitstream word stream
//            scan_clk            - registered scan clock to the tile chains
//            clb_scan_in/_en     - CLB chain serial data / shift enable
//            conn_scan_in/_en    - connection chain serial data / shift enable
//            busy, done          - load in progress / one-cycle completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_config_loader #(
  parameter int WORD_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 10,
  parameter int CONN_CHAIN_LEN = 36,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  scan_clk,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(WORD_WIDTH + 1);

  localparam logic [BCW-1:0]       WORD_BITS = BCW'(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CLB_LEN   = CNT_WIDTH'(CLB_CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] CONN_LEN  = CNT_WIDTH'(CONN_CHAIN_LEN);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_CLB  = 2'd1;
  localparam logic [1:0] S_LOAD_CONN = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [WORD_WIDTH-1:0] word_buf;
  logic [BCW-1:0]        buf_cnt;
  logic [CNT_WIDTH-1:0]  chain_cnt;
  logic                  phase;
  logic                  scan_bit;

  logic loading;
  logic accept;
  logic bit_end;
  logic chain_end;

  assign loading   = (state == S_LOAD_CLB) || (state == S_LOAD_CONN);
  assign accept    = in_valid && in_ready;
  // A bit completes at the edge that ends phase 1 (scan_clk falling).
  assign bit_end   = loading && (buf_cnt != '0) && phase;
  // The last bit of the chain: the chain counter would reach zero here, so
  // the state advances at this same edge and leftover word bits are dropped.
  assign chain_end = bit_end && (chain_cnt == CNT_WIDTH'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start)     next_state = S_LOAD_CLB;
      S_LOAD_CLB:  if (chain_end) next_state = S_LOAD_CONN;
      S_LOAD_CONN: if (chain_end) next_state = S_DONE;
      S_DONE:                     next_state = S_IDLE;
      default:                    next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (all derived from registers only)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready     = loading && (buf_cnt == '0);
    scan_clk     = phase;
    clb_scan_en  = (state == S_LOAD_CLB);
    conn_scan_en = (state == S_LOAD_CONN);
    clb_scan_in  = clb_scan_en && scan_bit;
    conn_scan_in = conn_scan_en && scan_bit;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Word buffer, bit phase and chain counting
  // --------------------------------------------------------------------------
  // scan_bit is a dedicated register rather than the buffer MSB so that the
  // serial line keeps its last value while the buffer is starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf  <= '0;
      buf_cnt   <= '0;
      chain_cnt <= '0;
      phase     <= 1'b0;
      scan_bit  <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      chain_cnt <= CLB_LEN;
      buf_cnt   <= '0;
      phase     <= 1'b0;
    end else if (accept) begin
      word_buf <= in_data;
      buf_cnt  <= WORD_BITS;
      phase    <= 1'b0;
      scan_bit <= in_data[WORD_WIDTH-1];
    end else if (loading && (buf_cnt != '0)) begin
      if (!phase) begin
        phase <= 1'b1;
      end else if (chain_end) begin
        phase     <= 1'b0;
        buf_cnt   <= '0;
        scan_bit  <= 1'b0;
        chain_cnt <= (state == S_LOAD_CLB) ? CONN_LEN : '0;
      end else begin
        phase     <= 1'b0;
        word_buf  <= word_buf << 1;
        buf_cnt   <= buf_cnt - BCW'(1);
        chain_cnt <= chain_cnt - CNT_WIDTH'(1);
        // On the last bit of a word the line holds until the next word.
        if (buf_cnt != BCW'(1)) begin
          scan_bit <= word_buf[WORD_WIDTH-2];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_config_loader.sv
`default_nettype none

module tb_scan_config_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, scan_clk, clb_scan_in, clb_scan_en;
  logic       conn_scan_in, conn_scan_en, busy, done;

  // second instance with an 8-bit CLB chain (exactly one word)
  logic       s8_start = 1'b0;
  logic       s8_valid = 1'b0;
  logic [7:0] s8_data = 8'h00;
  logic       s8_ready, s8_sclk, s8_clb_in, s8_clb_en;
  logic       s8_conn_in, s8_conn_en, s8_busy, s8_done;

  always #5 clk = ~clk;

  scan_config_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .scan_clk(scan_clk),
    .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
    .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en),
    .busy(busy), .done(done)
  );

  scan_config_loader #(.WORD_WIDTH(8), .CLB_CHAIN_LEN(8), .CONN_CHAIN_LEN(36), .CNT_WIDTH(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .in_data(s8_data),
    .in_valid(s8_valid), .in_ready(s8_ready), .scan_clk(s8_sclk),
    .clb_scan_in(s8_clb_in), .clb_scan_en(s8_clb_en),
    .conn_scan_in(s8_conn_in), .conn_scan_en(s8_conn_en),
    .busy(s8_busy), .done(s8_done)
  );

  localparam int L_CLB  = 10;
  localparam int L_CONN = 36;

  int errors = 0;
  int checks = 0;

  // scoreboard: expected serial bits per chain
  bit clb_q[$];
  bit conn_q[$];
  bit cyc_chk = 1'b0;

  int   clb_rises = 0, conn_rises = 0, clb_cyc = 0, conn_cyc = 0;
  logic prev_sclk = 1'b0, prev_in = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: a chain receives the first len bits of its words, MSB-first.
  task automatic push_chain(input logic [7:0] w[$], input int len, input bit conn);
    for (int i = 0; i < len; i++) begin
      logic [7:0] wd;
      wd = w[i / 8];
      if (conn) conn_q.push_back(wd[7 - (i % 8)]);
      else      clb_q.push_back(wd[7 - (i % 8)]);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic act_in;
    bit   exp_b;
    if (!rst_n) begin
      clb_rises = 0; conn_rises = 0; clb_cyc = 0; conn_cyc = 0;
      prev_sclk = 1'b0; prev_in = 1'b0; prev_done = 1'b0;
    end else begin
      act_in = clb_scan_en ? clb_scan_in : conn_scan_in;
      if (clb_scan_en && conn_scan_en) fail("both_enables_high");
      if (!clb_scan_en)  check("clb_in_gated", {31'd0, clb_scan_in}, 32'd0);
      if (!conn_scan_en) check("conn_in_gated", {31'd0, conn_scan_in}, 32'd0);
      if (scan_clk) check("scan_in_stable", {31'd0, act_in}, {31'd0, prev_in});
      if (clb_scan_en)  clb_cyc++;
      if (conn_scan_en) conn_cyc++;
      if (scan_clk && !prev_sclk) begin
        if (clb_scan_en) begin
          clb_rises++;
          if (clb_q.size() == 0) fail("clb_extra_bit");
          else begin
            exp_b = clb_q.pop_front();
            check("clb_bit", {31'd0, clb_scan_in}, {31'd0, exp_b});
          end
        end else if (conn_scan_en) begin
          conn_rises++;
          if (conn_q.size() == 0) fail("conn_extra_bit");
          else begin
            exp_b = conn_q.pop_front();
            check("conn_bit", {31'd0, conn_scan_in}, {31'd0, exp_b});
          end
        end else begin
          fail("spurious_scan_clk_rise");
        end
      end
      if (done) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        check("clb_rise_count", clb_rises, L_CLB);
        check("conn_rise_count", conn_rises, L_CONN);
        check("clb_q_left", clb_q.size(), 0);
        check("conn_q_left", conn_q.size(), 0);
        if (cyc_chk) begin
          check("clb_cycles", clb_cyc, (L_CLB + 7) / 8 + 2 * L_CLB);
          check("conn_cycles", conn_cyc, (L_CONN + 7) / 8 + 2 * L_CONN);
        end
        clb_rises = 0; conn_rises = 0; clb_cyc = 0; conn_cyc = 0;
      end
      prev_sclk = scan_clk;
      prev_in   = act_in;
      prev_done = done;
    end
  end

  // --------------------------------------------------------------- stimulus
  // gap = cycles to keep in_valid low after the loader becomes starved
  task automatic send_word(input logic [7:0] w, input int gap);
    int   t;
    logic hold;
    if (gap > 0) begin
      in_valid = 1'b0;
      t = 0;
      while (!in_ready && t < 400) begin @(negedge clk); t++; end
      if (t >= 400) fail("timeout_wait_starve");
      hold = clb_scan_en ? clb_scan_in : conn_scan_in;
      repeat (gap) begin
        check("starve_scan_clk", {31'd0, scan_clk}, 32'd0);
        check("starve_scan_in", {31'd0, (clb_scan_en ? clb_scan_in : conn_scan_in)}, {31'd0, hold});
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) fail("timeout_wait_ready");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] cw[$], input logic [7:0] nw[$],
                          input int fixgap, input int maxgap, input bit poke);
    int t;
    push_chain(cw, L_CLB, 1'b0);
    push_chain(nw, L_CONN, 1'b1);
    cyc_chk = (fixgap == 0) && (maxgap == 0) && !poke;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = cw[0];
    check("in_ready_idle", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("clb_en_first", {31'd0, clb_scan_en}, 32'd1);
    for (int i = 0; i < cw.size(); i++)
      send_word(cw[i], (i == 0) ? 0 : fixgap + int'($urandom_range(0, maxgap)));
    for (int i = 0; i < nw.size(); i++) begin
      send_word(nw[i], fixgap + int'($urandom_range(0, maxgap)));
      if (i == 0 && poke) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("poke_conn_en", {31'd0, conn_scan_en}, 32'd1);
        check("poke_no_consume", {31'd0, in_ready}, 32'd0);
      end
    end
    t = 0;
    while (!done && t < 600) begin @(negedge clk); t++; end
    if (t >= 600) fail("timeout_wait_done");
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("idle_after_done", {29'd0, busy, done, in_ready}, 32'd0);
  endtask

  function automatic logic [7:0] outs();
    return {in_ready, scan_clk, clb_scan_in, clb_scan_en,
            conn_scan_in, conn_scan_en, busy, done};
  endfunction

  initial begin
    logic [7:0] cw[$];
    logic [7:0] nw[$];
    int t, acc;
    bit seen;

    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {24'd0, outs()}, 32'd0);

    // directed: in_valid held high, exact timing
    cw = '{8'hA5, 8'hC0};
    nw = '{8'hFF, 8'h00, 8'h3C, 8'h81, 8'hF0};
    run_load(cw, nw, 0, 0, 1'b0);

    // directed: 7 starved cycles between words, start poked mid-connection load
    run_load(cw, nw, 7, 0, 1'b1);

    // randomized loads
    for (int n = 0; n < 6; n++) begin
      cw = {};
      nw = {};
      for (int i = 0; i < 2; i++) cw.push_back(8'($urandom));
      for (int i = 0; i < 5; i++) nw.push_back(8'($urandom));
      run_load(cw, nw, 0, int'($urandom_range(0, 5)), 1'($urandom));
    end

    // asynchronous reset during phase 1 of CLB bit 5
    cw = '{8'hA5, 8'hC0};
    push_chain(cw, L_CLB, 1'b0);
    cyc_chk = 1'b0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = cw[0];
    @(negedge clk);
    start = 1'b0;
    send_word(cw[0], 0);
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!(clb_rises == 4 && scan_clk) && t < 100);
    if (t >= 100) fail("timeout_bit5");
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", {24'd0, outs()}, 32'd0);
    clb_q = {};
    conn_q = {};
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {24'd0, outs()}, 32'd0);
    cw = '{8'h3C, 8'h96};
    nw = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_load(cw, nw, 0, 0, 1'b0);

    // 8-bit CLB chain: one word, then connection load ready on first cycle
    @(negedge clk);
    s8_start = 1'b1; s8_valid = 1'b1; s8_data = 8'h5A;
    acc = 0; seen = 1'b0; t = 0;
    @(negedge clk);
    s8_start = 1'b0;
    while (!s8_done && t < 400) begin
      if (s8_clb_en && s8_ready) acc++;
      if (s8_conn_en && !seen) begin
        seen = 1'b1;
        check("s8_conn_ready_first", {31'd0, s8_ready}, 32'd1);
        check("s8_clb_words", acc, 1);
      end
      @(negedge clk);
      s8_data = 8'($urandom);
      t++;
    end
    s8_valid = 1'b0;
    if (t >= 400) fail("timeout_s8_done");
    if (!seen) fail("s8_no_conn_phase");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
